// File: rtl/key_stream_fifo.sv
// key_stream_fifo
//   Elastic first-word-fall-through buffer between the chaotic-LFSR key
//   generator and the pixel decryptor. One {R,G,B} key triplet is captured per
//   key_ready cycle; the decryptor drains the head entry with key_take. Triplets
//   arriving while the buffer is full (and not being drained) are dropped,
//   flagged in a sticky overflow bit and counted in a saturating drop counter.
//
// Ports
//   clk, rst (async, active low)   clock and reset
//   flush                          synchronous clear of contents, overflow, drop_cnt
//   key_ready, r_in/g_in/b_in      generator side: one triplet per high cycle
//   key_valid, key_take            decryptor handshake (head available / consume)
//   r_out/g_out/b_out              head triplet, zero while empty
//   level, full, empty             registered occupancy status
//   overflow, drop_cnt             sticky drop flag, saturating drop count
module key_stream_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              key_ready,
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] g_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              key_valid,
  input  logic              key_take,
  output logic [DATA_W-1:0] r_out,
  output logic [DATA_W-1:0] g_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned     ENTRY_W   = 3 * DATA_W;
  localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              pop, push, drop, wr_en;
  logic [ENTRY_W-1:0] head;

  always_comb begin
    // pop is qualified by the registered empty flag, so a push into an empty
    // buffer with key_take high leaves the new entry in place.
    pop        = key_take & ~empty_q;
    push       = key_ready & (~full_q | pop);
    drop       = key_ready & full_q & ~pop;
    wr_en      = push & ~flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push && !pop)      level_d = level_q + (ADDR_W + 1)'(1);
      else if (pop && !push) level_d = level_q - (ADDR_W + 1)'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    full_d  = (level_d == LEVEL_MAX);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage carries no reset; empty_q masks whatever it holds.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {r_in, g_in, b_in};
  end

  assign head      = mem[rd_ptr_q];
  assign key_valid = ~empty_q;
  assign r_out     = empty_q ? '0 : head[ENTRY_W-1 -: DATA_W];
  assign g_out     = empty_q ? '0 : head[2*DATA_W-1 -: DATA_W];
  assign b_out     = empty_q ? '0 : head[DATA_W-1:0];
  assign level     = level_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
